// File: rtl/rf_up_2to4_if.sv
// rf_up_2to4_if: streaming bus of the 2-to-4 interpolator.
// 2 SPC in, 4 SPC out per channel; valid-only, no backpressure.
interface rf_up_2to4_if #(
    parameter int NUM_CHANNELS = 1
);
    logic [NUM_CHANNELS*64-1:0]  i_tdata;
    logic [NUM_CHANNELS-1:0]     i_tvalid;
    logic [NUM_CHANNELS*128-1:0] o_tdata;
    logic [NUM_CHANNELS-1:0]     o_tvalid;

    modport master (
        output i_tdata, i_tvalid,
        input  o_tdata, o_tvalid
    );

    modport slave (
        input  i_tdata, i_tvalid,
        output o_tdata, o_tvalid
    );
endinterface

// File: rtl/rf_up_2to4.sv
// rf_up_2to4: 2x half-band interpolator, 2 SPC in / 4 SPC out per channel.
// Kernel (-1,9,9,-1)/16, 3-stage pipe; RF_UP_2TO4_ROUND_EN selects round-half-up.
module rf_up_2to4 #(
    parameter int NUM_CHANNELS = 1
) (
    input logic         clk,
    input logic         rst_n,
    rf_up_2to4_if.slave bus
);

    wire [NUM_CHANNELS*128-1:0] w_o_tdata;
    wire [NUM_CHANNELS-1:0]     w_o_tvalid;

    function automatic logic [15:0] f_rnd_sat(
        input logic signed [21:0] i_d
    );
        logic signed [21:0] v_r;
`ifdef RF_UP_2TO4_ROUND_EN
        v_r = i_d + 22'sd8;
`else
        v_r = i_d;
`endif
        v_r = v_r >>> 4;
        if (v_r > 22'sd32767) begin
            return 16'h7fff;
        end else if (v_r < -22'sd32768) begin
            return 16'h8000;
        end else begin
            return v_r[15:0];
        end
    endfunction

    genvar g_ch, g_c;
    for (g_ch = 0; g_ch < NUM_CHANNELS; g_ch++) begin : g_chan
        logic r_v1;
        logic r_v2;
        logic r_v3;

        // Valid flags travel alongside the three data stages.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v1 <= 1'b0;
                r_v2 <= 1'b0;
                r_v3 <= 1'b0;
            end else begin
                r_v1 <= bus.i_tvalid[g_ch];
                r_v2 <= r_v1;
                r_v3 <= r_v2;
            end
        end

        assign w_o_tvalid[g_ch] = r_v3;

        for (g_c = 0; g_c < 2; g_c++) begin : g_comp
            logic signed [15:0] w_x0;
            logic signed [15:0] w_x1;
            logic signed [15:0] r_h1;
            logic signed [15:0] r_h2;
            logic signed [15:0] r_h3;
            logic signed [15:0] r_s1_p0;
            logic signed [15:0] r_s1_p2;
            logic signed [16:0] r_s1_a1;
            logic signed [16:0] r_s1_b1;
            logic signed [16:0] r_s1_a3;
            logic signed [16:0] r_s1_b3;
            logic signed [20:0] w_a9_1;
            logic signed [20:0] w_a9_3;
            logic signed [21:0] w_d1;
            logic signed [21:0] w_d3;
            logic signed [15:0] r_s2_p0;
            logic signed [15:0] r_s2_p2;
            logic signed [21:0] r_s2_d1;
            logic signed [21:0] r_s2_d3;
            logic [15:0]        r_y0;
            logic [15:0]        r_y1;
            logic [15:0]        r_y2;
            logic [15:0]        r_y3;

            assign w_x0 = bus.i_tdata[g_ch*64 + g_c*16 +: 16];
            assign w_x1 = bus.i_tdata[g_ch*64 + 32 + g_c*16 +: 16];

            // Sample history; idle cycles leave it alone so gaps vanish.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_h1 <= '0;
                    r_h2 <= '0;
                    r_h3 <= '0;
                end else if (bus.i_tvalid[g_ch]) begin
                    r_h1 <= w_x1;
                    r_h2 <= w_x0;
                    r_h3 <= r_h1;
                end
            end

            // S1: pair sums for mid(2k-2) and mid(2k-1), plus passthroughs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_p0 <= '0;
                    r_s1_p2 <= '0;
                    r_s1_a1 <= '0;
                    r_s1_b1 <= '0;
                    r_s1_a3 <= '0;
                    r_s1_b3 <= '0;
                end else if (bus.i_tvalid[g_ch]) begin
                    r_s1_p0 <= r_h2;
                    r_s1_p2 <= r_h1;
                    r_s1_a1 <= 17'(r_h2) + 17'(r_h1);
                    r_s1_b1 <= 17'(r_h3) + 17'(w_x0);
                    r_s1_a3 <= 17'(r_h1) + 17'(w_x0);
                    r_s1_b3 <= 17'(r_h2) + 17'(w_x1);
                end
            end

            assign w_a9_1 = (21'(r_s1_a1) <<< 3) + 21'(r_s1_a1);
            assign w_a9_3 = (21'(r_s1_a3) <<< 3) + 21'(r_s1_a3);
            assign w_d1   = 22'(w_a9_1) - 22'(r_s1_b1);
            assign w_d3   = 22'(w_a9_3) - 22'(r_s1_b3);

            // S2: 9*a - b, shift-and-add instead of a multiplier.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_p0 <= '0;
                    r_s2_p2 <= '0;
                    r_s2_d1 <= '0;
                    r_s2_d3 <= '0;
                end else if (r_v1) begin
                    r_s2_p0 <= r_s1_p0;
                    r_s2_p2 <= r_s1_p2;
                    r_s2_d1 <= w_d1;
                    r_s2_d3 <= w_d3;
                end
            end

            // S3: scale, saturate midpoints; hold output while idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y0 <= '0;
                    r_y1 <= '0;
                    r_y2 <= '0;
                    r_y3 <= '0;
                end else if (r_v2) begin
                    r_y0 <= r_s2_p0;
                    r_y1 <= f_rnd_sat(r_s2_d1);
                    r_y2 <= r_s2_p2;
                    r_y3 <= f_rnd_sat(r_s2_d3);
                end
            end

            assign w_o_tdata[g_ch*128 + 0  + g_c*16 +: 16] = r_y0;
            assign w_o_tdata[g_ch*128 + 32 + g_c*16 +: 16] = r_y1;
            assign w_o_tdata[g_ch*128 + 64 + g_c*16 +: 16] = r_y2;
            assign w_o_tdata[g_ch*128 + 96 + g_c*16 +: 16] = r_y3;
        end
    end

    assign bus.o_tdata  = w_o_tdata;
    assign bus.o_tvalid = w_o_tvalid;

endmodule

// File: doc/rf_up_2to4.md
Name: rf_up_2to4

Overview:
Single-clock 2x interpolator that accepts 2 SPC and outputs 4 SPC per channel. It is the transmit-direction counterpart of the 4-to-2 receive decimator. Interpolation uses a fixed 4-tap half-band kernel (-1, 9, 9, -1)/16 with an exact centre tap, so even outputs are passthrough. All DSP runs at the 1x clock, and the block sits ahead of the DAC-side 4 SPC data path.

Parameters:
- NUM_CHANNELS, 1, number of independent channels. Each channel has its own history and pipeline.

Ports:
- clk  in  1  sample clock; the only clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_tdata  in  NUM_CHANNELS*64  2 SPC per channel. Lane w at bits [ch*64+w*32 +: 32]; lane 0 is the earlier sample. Each sample is I in [15:0], Q in [31:16], 16-bit signed.
- i_tvalid  in  NUM_CHANNELS  per-channel input qualifier. No backpressure.
- o_tdata  out  NUM_CHANNELS*128  4 SPC per channel. Lane 0 is the earliest sample; same sample format as the input.
- o_tvalid  out  NUM_CHANNELS  per-channel output qualifier.

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- While rst_n=0: o_tdata=0, o_tvalid=0, history registers=0, pipeline valid flags=0. Reset mid-stream discards all in-flight data immediately.
- Notation: input word k carries x[2k] (lane 0) and x[2k+1] (lane 1).
- History: h1=x[2k-1], h2=x[2k-2], h3=x[2k-3].
  - History advances only on cycles where i_tvalid=1.
  - Idle cycles leave it untouched, so gaps are transparent.
- Define mid(n) = (9*(x[n]+x[n+1]) - (x[n-1]+x[n+2])) / 16. I and Q are filtered independently.
- Output group for input word k:
  - lane 0 = x[2k-2]
  - lane 1 = mid(2k-2)
  - lane 2 = x[2k-1]
  - lane 3 = mid(2k-1)
- This gives one input-word group delay. The first group after reset uses zero history.
- Width rules:
  - pair sums are 17 bits;
  - 9*sum is 21 bits, formed as (sum<<3)+sum with no DSP multiplier required;
  - the difference is 22 bits signed;
  - rounding (see Optional Feature) is applied, then arithmetic shift right by 4;
  - the result saturates to [-32768, 32767].
- Passthrough lanes are bit-exact copies and are never saturated.
- Pipeline: 3 registered stages.
  - S1: register the operand pair sums.
  - S2: compute 9*a - b.
  - S3: round, shift, saturate, and register the output.
- o_tvalid rises exactly 3 clk after the capturing i_tvalid cycle, and o_tdata is valid in that same cycle.
- Back-to-back valids produce back-to-back outputs, giving throughput of 1 word per clk.
- When o_tvalid=0, o_tdata holds its last value and downstream must ignore it.
- Channels never interact.
- No overflow or underflow is possible: there is no FIFO, and the input rate equals the output word rate.

Optional Feature:
- Macro: RF_UP_2TO4_ROUND_EN.
- Defined: add 8 before the >>4, giving round-half-up toward +inf.
- Undefined: plain >>4 (floor). Removes one 22-bit adder per lane.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- DC: drive constant I=Q=1000 for 4 valid words -> from the 3rd output group on, all lanes I=Q=1000.
- Impulse: I=1600 at x[0] (word 0 lane 0), all other inputs 0 ->
  - output stream y[-3..3] = -100, 0, 900, 1600, 900, 0, -100;
  - the following groups are all 0 (both rounding builds).
- Saturation: x = -32768, 32767, 32767, -32768 -> mid between the two 32767 samples = 32767 (raw 40958, clipped).
  - Symmetric negative case with x = 32767, -32768, -32768, 32767 clips to -32768.
- Rounding: x[n-1]=8, all others 0 -> mid(n)=0 with RF_UP_2TO4_ROUND_EN, -1 without.
- Gaps: i_tvalid pattern 1,0,0,1,1,0,1 with a ramp input ->
  - o_tvalid reproduces the pattern delayed by exactly 3 clk;
  - lane values match the gapless run.
- Reset mid-stream: drop rst_n during continuous valid ->
  - o_tvalid=0 and o_tdata=0 without waiting for a clk edge;
  - after release, the first group is lane0=0, lane1=mid computed with zero history.
